inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch front end for the multi-cycle RISC-V core. It owns the architectural PC register and fetches one instruction at a time from instruction memory over a request/response handshake. Fetched instructions go to decode over a valid/ready handshake. It consumes the `nextPC` computed by the execute-stage next-address logic through the redirect port and otherwise advances sequentially by 4.

## Interface
- `RESET_PC`, default 32'h80000000: PC loaded on reset.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: fetch request present.
- `imem_req_addr` out 32: fetch byte address, word aligned.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_resp_valid` in 1: response data valid this cycle.
- `imem_resp_data` in 32: fetched instruction word.
- `inst_valid` out 1: instruction held for decode.
- `inst` out 32: held instruction.
- `inst_pc` out 32: PC of the held instruction.
- `inst_ready` in 1: decode consumes the instruction this cycle.
- `redirect_valid` in 1: control-flow change; one-cycle pulse.
- `redirect_pc` in 32: new PC, i.e. `nextPC` from execute.
- `fetch_fault` out 1: sticky misaligned-redirect flag.
- `fetch_count` out 32: instructions delivered to decode; wraps.

## Operation
- **States:** REQ, WAIT, HOLD, FAULT.
- **REQ**
  - `imem_req_valid`=1 and `imem_req_addr`=pc.
  - When `imem_req_ready`=1, go to WAIT.
- **WAIT**
  - When `imem_resp_valid`=1, capture `imem_resp_data` into `inst` and pc into `inst_pc`, then go to HOLD.
  - Exception: if the kill flag is set, discard the response, clear kill, and go to REQ.
- **HOLD**
  - `inst_valid`=1.
  - On `inst_ready`=1: pc <= pc+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), `fetch_count`++, go to REQ.
- **Redirect (`redirect_valid`=1), handled per state:**
  - REQ: pc <= `redirect_pc`; stay in REQ. If `imem_req_ready` is also 1, that beat is the new address, because the address mux is combinational on redirect. The request is accepted and the state goes to WAIT.
  - WAIT without a response this cycle: pc <= `redirect_pc`; set kill.
  - WAIT with a response this cycle: drop the response, pc <= `redirect_pc`, go to REQ; kill stays clear.
  - HOLD: drop the held instruction and go to REQ with pc <= `redirect_pc`.
  - HOLD with `inst_ready`=1 in the same cycle: the handshake completes (count increments), but redirect wins the PC, so pc <= `redirect_pc`, not pc+4.
- **Misaligned target:** if `redirect_pc[1:0]`≠0, set `fetch_fault` and go to FAULT.
  - In WAIT, set kill first so a late response is absorbed.
- **FAULT:** `imem_req_valid`=0 and `inst_valid`=0; only `rst` exits.
  - Responses arriving in FAULT are ignored.
  - Redirects arriving in FAULT are ignored.
- **Outstanding requests:** at most one.
  - The memory never returns a response without an accepted request.
  - A response in REQ or HOLD is a protocol error and is ignored.

## Timing
- **Reset:** `rst` high at an edge sets:
  - state=REQ, pc=`RESET_PC`;
  - kill=0, `fetch_count`=0, `fetch_fault`=0;
  - `inst`=0, `inst_pc`=0.
- **Outputs during reset:**
  - While `rst` is high, `imem_req_valid`=0 and `inst_valid`=0.
  - The first request appears in the first cycle after `rst` falls.
- **Reset mid-operation:** abandons any outstanding request, with no kill carried across reset. The memory side is reset by the same `rst`.
- **Registered outputs:** `inst_valid`, `inst`, `inst_pc`, `fetch_count` and `fetch_fault` are registered.
- **Combinational outputs:** `imem_req_valid` and `imem_req_addr` are combinational from state and pc, plus the redirect override in REQ.
- **Best-case latency:** request accepted at cycle 0, response at cycle 1, `inst_valid` at cycle 2, consumed at cycle 2, next request at cycle 3. That is 3 cycles per instruction.
- **Redirect latency:**
  - Redirect in HOLD at cycle n gives a request at cycle n+1 with the new address.
  - Redirect in REQ takes effect in the same cycle.
- **Stability:** `inst` and `inst_pc` stay stable while `inst_valid`=1 and `inst_ready`=0.
- **Request stability:** `imem_req_addr` stays stable while stalled, except on a redirect.

## Test plan
- **Reset and straight-line fetch:** release reset, memory ready always, response 1 cycle later, `inst_ready`=1.
  - Requests go to 80000000, 80000004, 80000008.
  - `inst_valid` is asserted every 3rd cycle.
  - `fetch_count`=3 after the third handoff.
- **Decode stall:** hold `inst_ready`=0 for 5 cycles in HOLD.
  - `inst` and `inst_pc` stay constant.
  - No new request is issued.
  - Releasing the stall gives a request at pc+4 next cycle.
- **Redirect in WAIT:** redirect_pc=80000100 while a response is outstanding, response 3 cycles later.
  - The response is dropped and `inst_valid` stays 0.
  - The next request goes to 80000100.
  - The instruction delivered has `inst_pc`=80000100.
- **Simultaneous redirect and handoff in HOLD:** redirect_pc=80000040 with `inst_ready`=1.
  - `fetch_count` increments.
  - The next request goes to 80000040, not pc+4.
- **Wrap-around:** RESET_PC=FFFFFFFC, straight-line fetch.
  - The second request goes to 00000000.
- **Misaligned redirect:** redirect_pc=80000002.
  - `fetch_fault`=1 next cycle.
  - No further requests or `inst_valid` until `rst`.
  - Asserting `rst` clears `fetch_fault`, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request at a time,
// and hands fetched words to decode over a valid/ready handshake.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;
  logic        misaligned;

  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      count_q      <= 32'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (misaligned)          state_d = S_FAULT;
        else if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (misaligned) state_d = S_FAULT;
        else if (imem_resp_valid)
          state_d = (kill_q || redirect_valid) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (misaligned)                        state_d = S_FAULT;
        else if (redirect_valid || inst_ready) state_d = S_REQ;
      end
      default: state_d = S_FAULT;
    endcase
  end

  // Datapath updates; a redirect always wins the PC over the sequential pc+4.
  always_comb begin
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    count_d   = count_q;
    fault_d   = fault_q;
    case (state_q)
      S_REQ: begin
        if (misaligned)          fault_d = 1'b1;
        else if (redirect_valid) pc_d    = redirect_pc;
      end
      S_WAIT: begin
        if (misaligned) begin
          fault_d = 1'b1;
          kill_d  = 1'b1;
        end else if (imem_resp_valid) begin
          kill_d = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (!kill_q) begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) count_d = count_q + 32'd1;
        if (misaligned)          fault_d = 1'b1;
        else if (redirect_valid) pc_d    = redirect_pc;
        else if (inst_ready)     pc_d    = pc_q + 32'd4;
      end
      default: ;
    endcase
  end

  // A misaligned redirect in REQ suppresses the request rather than issuing a bad address.
  always_comb begin
    inst_valid_d   = (state_d == S_HOLD);
    imem_req_valid = !rst && (state_q == S_REQ) && !misaligned;
    imem_req_addr  = (state_q == S_REQ && redirect_valid) ? redirect_pc : pc_q;
  end

  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_count = count_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: straight-line fetch, stall, redirects,
// wrap-around (second instance) and the misaligned-redirect fault.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_ready, imem_resp_valid, inst_ready, redirect_valid;
  logic [31:0] imem_resp_data, redirect_pc;

  logic        imem_req_valid, inst_valid, fetch_fault;
  logic [31:0] imem_req_addr, inst, inst_pc, fetch_count;

  logic        w_req_valid, w_inst_valid, w_fetch_fault;
  logic [31:0] w_req_addr, w_inst, w_inst_pc, w_fetch_count;

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  inst_fetch #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(w_inst_valid), .inst(w_inst),
    .inst_pc(w_inst_pc), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(w_fetch_fault), .fetch_count(w_fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic rdv, input logic [31:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    inst_ready      = ir;
    redirect_valid  = rdv;
    redirect_pc     = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ; one request, a response the next cycle, consumed immediately.
  task automatic fetchOne(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkBit("req_valid", imem_req_valid, 1'b1);
    checkOutput("req_addr", imem_req_addr, a);
    tick();
    applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0);
    checkBit("wait_no_inst_valid", inst_valid, 1'b0);
    checkBit("wait_no_req", imem_req_valid, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkBit("hold_inst_valid", inst_valid, 1'b1);
    checkOutput("hold_inst", inst, d);
    checkOutput("hold_inst_pc", inst_pc, a);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkBit("rst_req_valid", imem_req_valid, 1'b0);
    checkBit("rst_inst_valid", inst_valid, 1'b0);
    checkOutput("rst_count", fetch_count, 32'h0);
    checkBit("rst_fault", fetch_fault, 1'b0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);

    rst = 1'b0;
    fetchOne(32'h80000000, 32'h00000013);
    checkOutput("count_1", fetch_count, 32'd1);
    fetchOne(32'h80000004, 32'h00100093);
    fetchOne(32'h80000008, 32'h00200113);
    checkOutput("count_3", fetch_count, 32'd3);

    // Decode stall for 5 cycles in HOLD
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_req_addr", imem_req_addr, 32'h8000000C);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hAAAA0001, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkBit("stall_inst_valid", inst_valid, 1'b1);
      checkOutput("stall_inst", inst, 32'hAAAA0001);
      checkOutput("stall_inst_pc", inst_pc, 32'h8000000C);
      checkBit("stall_no_req", imem_req_valid, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkBit("unstall_req_valid", imem_req_valid, 1'b1);
    checkOutput("unstall_req_addr", imem_req_addr, 32'h80000010);
    checkOutput("count_4", fetch_count, 32'd4);

    // Redirect while a response is outstanding; the late response must be dropped
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80000100);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    checkBit("kill_wait_no_req", imem_req_valid, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkBit("killed_inst_valid", inst_valid, 1'b0);
    checkBit("kill_req_valid", imem_req_valid, 1'b1);
    checkOutput("kill_req_addr", imem_req_addr, 32'h80000100);
    fetchOne(32'h80000100, 32'h11111111);
    checkOutput("count_5", fetch_count, 32'd5);

    // Redirect and handoff in the same HOLD cycle
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hold2_inst_pc", inst_pc, 32'h80000104);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80000040);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("count_6", fetch_count, 32'd6);
    checkOutput("redir_hold_addr", imem_req_addr, 32'h80000040);
    checkBit("redir_hold_inst_valid", inst_valid, 1'b0);

    // Redirect in REQ overrides the address combinationally
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80000200);
    checkOutput("redir_req_addr", imem_req_addr, 32'h80000200);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("redir_req_inst_pc", inst_pc, 32'h80000200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();

    // Misaligned redirect in REQ
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80000002);
    tick();
    checkBit("fault_set", fetch_fault, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 32'h80000300);
      checkBit("fault_no_req", imem_req_valid, 1'b0);
      checkBit("fault_no_inst", inst_valid, 1'b0);
      tick();
    end
    checkBit("fault_sticky", fetch_fault, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    checkBit("fault_cleared", fetch_fault, 1'b0);
    checkBit("rst2_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst2_count", fetch_count, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkBit("restart_req_valid", imem_req_valid, 1'b1);
    checkOutput("restart_addr", imem_req_addr, 32'h80000000);

    // Wrap-around on the instance reset to FFFFFFFC
    checkOutput("wrap_addr0", w_req_addr, 32'hFFFFFFFC);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wrap_inst_pc", w_inst_pc, 32'hFFFFFFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkBit("wrap_req_valid", w_req_valid, 1'b1);
    checkOutput("wrap_addr1", w_req_addr, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
